// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - reservation-station issue scheduler with CDB writeback reservation table
module rs_issue_sched #(
   parameter int RSLEN     = 16,
   parameter int NUM_ALU   = 3,
   parameter int MULT_LAT  = 4,
   parameter int CDB_WIDTH = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     squash_flag,
   input  logic [RSLEN-1:0]         ready,
   input  logic [2*RSLEN-1:0]       fu_type,
   input  logic                     mem_busy,
   output logic [NUM_ALU*RSLEN-1:0] alu_gnt,
   output logic [RSLEN-1:0]         mult_gnt,
   output logic [RSLEN-1:0]         mem_gnt,
   output logic [RSLEN-1:0]         clear,
   output logic                     mult_busy
);
   localparam int PW = (RSLEN > 1) ? $clog2(RSLEN) : 1;
   localparam int CW = $clog2(CDB_WIDTH + 1);
   localparam int MW = $clog2(MULT_LAT);

   logic [PW-1:0]            ptr, ptr_n;
   logic [CW-1:0]            res   [1:MULT_LAT];
   logic [CW-1:0]            res_n [1:MULT_LAT];
   logic [MW-1:0]            mult_cnt, mult_cnt_n;
   logic [RSLEN-1:0]         elig, mult_sel, mem_sel, clr_sel;
   logic [NUM_ALU*RSLEN-1:0] alu_sel;
   int                       n_alu, n_mem, n_mult, first_off, idx;

   // index of the entry 'off' positions after 'base', wrapping at RSLEN
   function automatic int wrap(input int base, input int off);
      int s;
      s = base + off;
      return (s >= RSLEN) ? s - RSLEN : s;
   endfunction

   // entries granted last cycle are still marked busy by the RS, so they are masked here
   assign elig = enable ? (ready & ~clear) : '0;

   // Round-robin selection (multiplier, then LSU, then ALU rows) and next-state of table/counter/pointer
   always_comb begin
      mult_sel  = '0;
      mem_sel   = '0;
      alu_sel   = '0;
      n_alu     = 0;
      n_mem     = 0;
      n_mult    = 0;
      first_off = RSLEN;
      idx       = 0;
      for (int k = 1; k <= MULT_LAT; k++) res_n[k] = '0;

      for (int off = 0; off < RSLEN; off++) begin
         idx = wrap(int'(ptr), off);
         if (n_mult == 0 && !mult_busy && elig[idx] && fu_type[2*idx +: 2] == 2'b01 &&
             int'(res[MULT_LAT]) + 1 <= CDB_WIDTH) begin
            mult_sel[idx] = 1'b1;
            n_mult        = 1;
            if (off < first_off) first_off = off;
         end
      end

      // when MULT_LAT is 2 the multiplier and LSU land in the same CDB slot
      for (int off = 0; off < RSLEN; off++) begin
         idx = wrap(int'(ptr), off);
         if (n_mem == 0 && !mem_busy && elig[idx] && fu_type[2*idx +: 2] == 2'b10 &&
             int'(res[2]) + ((MULT_LAT == 2) ? n_mult : 0) + 1 <= CDB_WIDTH) begin
            mem_sel[idx] = 1'b1;
            n_mem        = 1;
            if (off < first_off) first_off = off;
         end
      end

      for (int off = 0; off < RSLEN; off++) begin
         idx = wrap(int'(ptr), off);
         if (n_alu < NUM_ALU && elig[idx] && fu_type[2*idx] == fu_type[2*idx+1] &&
             int'(res[1]) + n_alu + 1 <= CDB_WIDTH) begin
            alu_sel[n_alu*RSLEN + idx] = 1'b1;
            n_alu                      = n_alu + 1;
            if (off < first_off) first_off = off;
         end
      end

      clr_sel = mult_sel | mem_sel;
      for (int r = 0; r < NUM_ALU; r++) clr_sel = clr_sel | alu_sel[r*RSLEN +: RSLEN];

      // slot k+1 moves down to k; ALU results (distance 1) are due next cycle and leave the table
      for (int k = 1; k < MULT_LAT; k++) begin
         res_n[k] = res[k+1] + CW'((k + 1 == 2) ? n_mem : 0) + CW'((k + 1 == MULT_LAT) ? n_mult : 0);
      end
      res_n[MULT_LAT] = '0;

      ptr_n      = (first_off < RSLEN) ? PW'(wrap(int'(ptr), first_off + 1)) : ptr;
      mult_cnt_n = (n_mult != 0) ? MW'(MULT_LAT - 1) :
                   ((mult_cnt != '0) ? mult_cnt - MW'(1) : '0);
   end

   // Registered grants, reservation table, multiplier occupancy and scan pointer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alu_gnt   <= '0;
         mult_gnt  <= '0;
         mem_gnt   <= '0;
         clear     <= '0;
         mult_busy <= 1'b0;
         mult_cnt  <= '0;
         ptr       <= '0;
         for (int k = 1; k <= MULT_LAT; k++) res[k] <= '0;
      end else if (squash_flag) begin
         alu_gnt   <= '0;
         mult_gnt  <= '0;
         mem_gnt   <= '0;
         clear     <= '0;
         mult_busy <= 1'b0;
         mult_cnt  <= '0;
         ptr       <= '0;
         for (int k = 1; k <= MULT_LAT; k++) res[k] <= '0;
      end else begin
         alu_gnt   <= alu_sel;
         mult_gnt  <= mult_sel;
         mem_gnt   <= mem_sel;
         clear     <= clr_sel;
         mult_busy <= (mult_cnt_n != '0);
         mult_cnt  <= mult_cnt_n;
         ptr       <= ptr_n;
         for (int k = 1; k <= MULT_LAT; k++) res[k] <= res_n[k];
      end
   end
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - scoreboard bench for rs_issue_sched with a slot-based reference model
module tb_rs_issue_sched;
   localparam int RSLEN     = 16;
   localparam int NUM_ALU   = 3;
   localparam int MULT_LAT  = 4;
   localparam int CDB_WIDTH = 3;
   localparam int AW        = NUM_ALU * RSLEN;

   logic             clock       = 1'b0;
   logic             reset       = 1'b1;
   logic             enable      = 1'b0;
   logic             squash_flag = 1'b0;
   logic             mem_busy    = 1'b0;
   logic [RSLEN-1:0]   ready     = '0;
   logic [2*RSLEN-1:0] fu_type   = '0;
   logic [AW-1:0]      alu_gnt;
   logic [RSLEN-1:0]   mult_gnt, mem_gnt, clear;
   logic               mult_busy;

   always #5 clock = ~clock;

   rs_issue_sched #(
      .RSLEN(RSLEN), .NUM_ALU(NUM_ALU), .MULT_LAT(MULT_LAT), .CDB_WIDTH(CDB_WIDTH)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .squash_flag(squash_flag),
      .ready(ready), .fu_type(fu_type), .mem_busy(mem_busy),
      .alu_gnt(alu_gnt), .mult_gnt(mult_gnt), .mem_gnt(mem_gnt), .clear(clear),
      .mult_busy(mult_busy)
   );

   typedef struct {
      logic [AW-1:0]    alu;
      logic [RSLEN-1:0] mult;
      logic [RSLEN-1:0] mem;
      logic [RSLEN-1:0] clr;
      logic             busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference state: absolute cycle number, CDB occupancy per absolute cycle, multiplier free time
   int               m_ptr     = 0;
   int               cyc       = 0;
   int               mult_free = 0;
   int               slot[int];
   logic [RSLEN-1:0] m_prev    = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic int used(input int s);
      return slot.exists(s) ? slot[s] : 0;
   endfunction

   function automatic int unit_of(input int i);
      logic [1:0] t;
      t = fu_type[2*i +: 2];
      if (t == 2'b01) return 1;
      if (t == 2'b10) return 2;
      return 0;
   endfunction

   function automatic logic [2*RSLEN-1:0] set_fu(input logic [2*RSLEN-1:0] f, input int i,
                                                input logic [1:0] c);
      f[2*i +: 2] = c;
      return f;
   endfunction

   task automatic model_reset();
      m_ptr     = 0;
      mult_free = 0;
      slot.delete();
      m_prev    = '0;
   endtask

   // predicts the registered outputs after the coming edge from the inputs now applied
   task automatic model_step();
      exp_t e;
      int   scan[$];
      int   firstpos;
      int   na;
      e.alu = '0; e.mult = '0; e.mem = '0; e.clr = '0; e.busy = 1'b0;
      firstpos = RSLEN;
      na = 0;
      if (!squash_flag && enable) begin
         for (int o = 0; o < RSLEN; o++)
            if (ready[(m_ptr + o) % RSLEN] && !m_prev[(m_ptr + o) % RSLEN])
               scan.push_back((m_ptr + o) % RSLEN);
         if (cyc >= mult_free)
            for (int p = 0; p < scan.size(); p++)
               if (unit_of(scan[p]) == 1 && e.mult == '0 && used(cyc + MULT_LAT) < CDB_WIDTH) begin
                  e.mult[scan[p]] = 1'b1;
                  slot[cyc + MULT_LAT] = used(cyc + MULT_LAT) + 1;
                  mult_free = cyc + MULT_LAT;
                  if (p < firstpos) firstpos = p;
               end
         if (!mem_busy)
            for (int p = 0; p < scan.size(); p++)
               if (unit_of(scan[p]) == 2 && e.mem == '0 && used(cyc + 2) < CDB_WIDTH) begin
                  e.mem[scan[p]] = 1'b1;
                  slot[cyc + 2] = used(cyc + 2) + 1;
                  if (p < firstpos) firstpos = p;
               end
         for (int p = 0; p < scan.size(); p++)
            if (unit_of(scan[p]) == 0 && na < NUM_ALU && used(cyc + 1) < CDB_WIDTH) begin
               e.alu[na*RSLEN + scan[p]] = 1'b1;
               slot[cyc + 1] = used(cyc + 1) + 1;
               na++;
               if (p < firstpos) firstpos = p;
            end
         if (firstpos < RSLEN) m_ptr = (scan[firstpos] + 1) % RSLEN;
      end
      if (squash_flag) begin
         e.alu = '0; e.mult = '0; e.mem = '0;
         model_reset();
      end else begin
         e.clr = e.mult | e.mem;
         for (int r = 0; r < NUM_ALU; r++) e.clr = e.clr | e.alu[r*RSLEN +: RSLEN];
         m_prev = e.clr;
         e.busy = (cyc + 1 < mult_free);
      end
      exp_q.push_back(e);
      cyc++;
   endtask

   task automatic cycle(input logic [RSLEN-1:0] r, input logic [2*RSLEN-1:0] f,
                        input logic en, input logic sq, input logic mb);
      @(negedge clock);
      reset       = 1'b1;
      ready       = r;
      fu_type     = f;
      enable      = en;
      squash_flag = sq;
      mem_busy    = mb;
      model_step();
   endtask

   task automatic after_edge();
      @(posedge clock);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("alu_gnt",   64'(alu_gnt),   64'(e.alu));
            check("mult_gnt",  64'(mult_gnt),  64'(e.mult));
            check("mem_gnt",   64'(mem_gnt),   64'(e.mem));
            check("clear",     64'(clear),     64'(e.clr));
            check("mult_busy", 64'(mult_busy), 64'(e.busy));
         end
      end
   end

   initial begin : stim
      logic [2*RSLEN-1:0] f;
      logic [AW-1:0]      a;
      logic [RSLEN-1:0]   r;
      logic [2*RSLEN-1:0] fr;
      #1 reset = 1'b0;
      #1;
      check("reset_alu",   64'(alu_gnt),   64'd0);
      check("reset_mult",  64'(mult_gnt),  64'd0);
      check("reset_mem",   64'(mem_gnt),   64'd0);
      check("reset_clear", 64'(clear),     64'd0);
      check("reset_busy",  64'(mult_busy), 64'd0);

      // four ALU entries, first edge out of reset
      cycle(16'h0027, '0, 1'b1, 1'b0, 1'b0);
      after_edge();
      a = '0; a[0] = 1'b1; a[RSLEN+1] = 1'b1; a[2*RSLEN+2] = 1'b1;
      check("four_alu_first", 64'(alu_gnt), 64'(a));
      cycle(16'h0027, '0, 1'b1, 1'b0, 1'b0);
      after_edge();
      a = '0; a[5] = 1'b1;
      check("four_alu_second", 64'(alu_gnt), 64'(a));

      // multiplier occupancy
      cycle('0, '0, 1'b1, 1'b1, 1'b0);
      f = set_fu('0, 4, 2'b01);
      f = set_fu(f, 6, 2'b01);
      cycle(16'h0050, f, 1'b1, 1'b0, 1'b0);
      after_edge();
      check("mult_first", 64'(mult_gnt), 64'h0010);
      check("mult_busy_set", 64'(mult_busy), 64'd1);
      for (int k = 0; k < 3; k++) begin
         cycle(16'h0040, f, 1'b1, 1'b0, 1'b0);
         after_edge();
         check("mult_held", 64'(mult_gnt), 64'd0);
         check("mult_busy_run", 64'(mult_busy), (k < 2) ? 64'd1 : 64'd0);
      end
      cycle(16'h0040, f, 1'b1, 1'b0, 1'b0);
      after_edge();
      check("mult_second", 64'(mult_gnt), 64'h0040);

      // CDB cap: multiplier result lands in the same slot as the ALU results three cycles later
      cycle('0, '0, 1'b1, 1'b0, 1'b0);
      cycle('0, '0, 1'b1, 1'b0, 1'b0);
      cycle(16'h0007, '0, 1'b1, 1'b0, 1'b0);
      after_edge();
      a = '0; a[0] = 1'b1; a[RSLEN+1] = 1'b1;
      check("cdb_cap_alu", 64'(alu_gnt), 64'(a));

      // squash during a multiply and with ALU entries ready
      f = set_fu('0, 8, 2'b01);
      cycle(16'h0100, f, 1'b1, 1'b0, 1'b0);
      after_edge();
      check("pre_squash_mult", 64'(mult_gnt), 64'h0100);
      cycle(16'h0038, '0, 1'b1, 1'b1, 1'b0);
      after_edge();
      check("squash_alu", 64'(alu_gnt), 64'd0);
      check("squash_busy", 64'(mult_busy), 64'd0);
      f = set_fu('0, 10, 2'b01);
      cycle(16'h4402, f, 1'b1, 1'b0, 1'b0);
      after_edge();
      a = '0; a[1] = 1'b1; a[RSLEN+14] = 1'b1;
      check("post_squash_alu_ptr0", 64'(alu_gnt), 64'(a));
      check("post_squash_mult", 64'(mult_gnt), 64'h0400);

      // LSU stall
      f = set_fu('0, 5, 2'b10);
      for (int k = 0; k < 3; k++) begin
         cycle(16'h0020, f, 1'b1, 1'b0, 1'b1);
         after_edge();
         check("mem_stalled", 64'(mem_gnt), 64'd0);
      end
      cycle(16'h0020, f, 1'b1, 1'b0, 1'b0);
      after_edge();
      check("mem_released", 64'(mem_gnt), 64'h0020);

      // asynchronous reset in the middle of grants and a multiply
      f = set_fu('0, 2, 2'b01);
      cycle(16'h0007, f, 1'b1, 1'b0, 1'b0);
      after_edge();
      a = '0; a[0] = 1'b1; a[RSLEN+1] = 1'b1;
      check("pre_reset_alu", 64'(alu_gnt), 64'(a));
      check("pre_reset_mult", 64'(mult_gnt), 64'h0004);
      #2;
      ready = '0; enable = 1'b0; reset = 1'b0;
      #1;
      check("async_reset_alu",   64'(alu_gnt),   64'd0);
      check("async_reset_mult",  64'(mult_gnt),  64'd0);
      check("async_reset_clear", 64'(clear),     64'd0);
      check("async_reset_busy",  64'(mult_busy), 64'd0);
      model_reset();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r  = 16'($urandom);
         if ($urandom_range(1) == 0) r = r & 16'($urandom);
         fr = {16'($urandom), 16'($urandom)};
         cycle(r, fr, ($urandom % 10) != 0, ($urandom % 40) == 0, ($urandom % 3) == 0);
      end

      @(posedge clock);
      #2;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
